// File: rtl/div_pkg.sv
// Shared divider definitions: op-select bit indices, datapath widths and the
// divider FSM state encoding. Imported by decode/execute/memory and the divider.
package div_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 6;
   localparam int unsigned OP_W  = 4;

   // Bit positions inside the one-hot div_op field
   localparam int unsigned DIV_W  = 0;
   localparam int unsigned DIV_WU = 1;
   localparam int unsigned MOD_W  = 2;
   localparam int unsigned MOD_WU = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_iter_unit_if.sv
// Divider request/response channel between the pipeline and div_iter_unit.
//   req:  div_req_valid/div_req_ready, div_op, div_src1, div_src2, div_cancel
//   resp: div_resp_valid/div_resp_ready, div_quotient, div_remainder, div_busy
// master = pipeline side (execute/memory stages), slave = divider.
interface div_iter_unit_if;
   import div_pkg::*;

   logic               div_req_valid;
   logic               div_req_ready;
   logic [OP_W-1:0]    div_op;
   logic [XLEN-1:0]    div_src1;
   logic [XLEN-1:0]    div_src2;
   logic               div_cancel;
   logic               div_resp_valid;
   logic               div_resp_ready;
   logic [XLEN-1:0]    div_quotient;
   logic [XLEN-1:0]    div_remainder;
   logic               div_busy;

   modport master (
      output div_req_valid, div_op, div_src1, div_src2, div_cancel, div_resp_ready,
      input  div_req_ready, div_resp_valid, div_quotient, div_remainder, div_busy
   );

   modport slave (
      input  div_req_valid, div_op, div_src1, div_src2, div_cancel, div_resp_ready,
      output div_req_ready, div_resp_valid, div_quotient, div_remainder, div_busy
   );

endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate. Used for operand magnitude at accept
// and for quotient/remainder sign restoration at fixup.
//   value  : input word
//   negate : when high, result = -value, otherwise result = value
//   result : output word
module div_sign_fix
   import div_pkg::*;
(
   input  logic [XLEN-1:0] value,
   input  logic            negate,
   output logic [XLEN-1:0] result
);

   assign result = negate ? XLEN'(-value) : value;

endmodule

// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring 32-bit divider for DIV.W/DIV.WU/MOD.W/MOD.WU.
// Always returns both quotient and remainder, 33 edges after accept.
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : slave side of div_iter_unit_if (request, response, cancel, busy)
module div_iter_unit
   import div_pkg::*;
(
   input  logic      clk,
   input  logic      resetn,
   div_iter_unit_if.slave bus
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN:0]    rem_q;
   logic [XLEN-1:0]  quo_q;
   logic [XLEN-1:0]  divisor_q;
   logic [XLEN-1:0]  src1_q;
   logic             q_neg_q, r_neg_q, div_zero_q;
   logic [XLEN-1:0]  quotient_q, remainder_q;

   logic             accept_c, is_signed_c, calc_last_c;
   logic [XLEN-1:0]  abs1_c, abs2_c, qfix_c, rfix_c;
   logic [XLEN:0]    rem_shift_c, diff_c;
   logic             unused_c;

   assign is_signed_c = bus.div_op[DIV_W] | bus.div_op[MOD_W];
   assign unused_c    = ^{rem_q[XLEN], bus.div_op[DIV_WU], bus.div_op[MOD_WU]};

   // Handshake: a new op may enter when idle, or when the current result leaves
   assign bus.div_req_ready = resetn & ~bus.div_cancel &
                              ((state_q == ST_IDLE) |
                               ((state_q == ST_DONE) & bus.div_resp_ready));
   assign accept_c          = bus.div_req_valid & bus.div_req_ready;
   assign calc_last_c       = (cnt_q == CNT_W'(XLEN - 1));

   assign bus.div_resp_valid = (state_q == ST_DONE);
   assign bus.div_busy       = (state_q != ST_IDLE);
   assign bus.div_quotient   = quotient_q;
   assign bus.div_remainder  = remainder_q;

   div_sign_fix u_abs1 (.value(bus.div_src1), .negate(is_signed_c & bus.div_src1[XLEN-1]), .result(abs1_c));
   div_sign_fix u_abs2 (.value(bus.div_src2), .negate(is_signed_c & bus.div_src2[XLEN-1]), .result(abs2_c));
   div_sign_fix u_qfix (.value(quo_q),            .negate(q_neg_q), .result(qfix_c));
   div_sign_fix u_rfix (.value(rem_q[XLEN-1:0]),  .negate(r_neg_q), .result(rfix_c));

   // One restoring step: shift in next dividend bit, trial-subtract divisor
   always_comb begin
      rem_shift_c = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
      diff_c      = rem_shift_c - {1'b0, divisor_q};
   end

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; cancel overrides everything
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept_c)    state_d = ST_CALC;
         ST_CALC: if (calc_last_c) state_d = ST_FIX;
         ST_FIX:                   state_d = ST_DONE;
         ST_DONE: if (bus.div_resp_ready) state_d = accept_c ? ST_CALC : ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
      if (bus.div_cancel) state_d = ST_IDLE;
   end

   // Datapath: operand capture, iteration, result fixup
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         divisor_q   <= '0;
         src1_q      <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         div_zero_q  <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else if (accept_c) begin
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= abs1_c;
         divisor_q  <= abs2_c;
         src1_q     <= bus.div_src1;
         q_neg_q    <= is_signed_c & (bus.div_src1[XLEN-1] ^ bus.div_src2[XLEN-1]);
         r_neg_q    <= is_signed_c & bus.div_src1[XLEN-1];
         div_zero_q <= (bus.div_src2 == '0);
      end else if (!bus.div_cancel) begin
         if (state_q == ST_CALC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (!diff_c[XLEN]) begin
               rem_q <= diff_c;
               quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
               rem_q <= rem_shift_c;
               quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
         end else if (state_q == ST_FIX) begin
            // Divide-by-zero returns all-ones quotient and the untouched dividend
            quotient_q  <= div_zero_q ? '1 : qfix_c;
            remainder_q <= div_zero_q ? src1_q : rfix_c;
         end
      end
   end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed self-checking bench for div_iter_unit.
module tb_div_iter_unit;

   logic clk;
   logic resetn;
   int   checks;
   int   errors;

   div_iter_unit_if bus ();

   div_iter_unit dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Present a request and hold it through the accept edge (bounded wait for ready)
   task automatic do_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int w;
      w = 0;
      bus.div_req_valid = 1'b1;
      bus.div_op        = op;
      bus.div_src1      = a;
      bus.div_src2      = b;
      while (!bus.div_req_ready && w < 100) begin
         @(posedge clk); #1; w++;
      end
      if (w >= 100) begin
         checks++; errors++;
         $display("FAIL issue_timeout got ready=%b exp 1", bus.div_req_ready);
      end
      @(posedge clk); #1;
      bus.div_req_valid = 1'b0;
      bus.div_src1      = 32'hDEAD_BEEF;
      bus.div_src2      = 32'h0BAD_F00D;
   endtask

   // Count edges from the accept edge until resp_valid (bounded)
   task automatic wait_resp(output int n);
      n = 0;
      while (!bus.div_resp_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic take_resp();
      bus.div_resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.div_resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.div_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.div_resp_valid); end
      checks++; if (bus.div_quotient !== 32'h0) begin errors++; $display("FAIL rst_q got %h exp 0", bus.div_quotient); end
      checks++; if (bus.div_remainder !== 32'h0) begin errors++; $display("FAIL rst_r got %h exp 0", bus.div_remainder); end
      checks++; if (bus.div_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.div_busy); end
      bus.div_req_valid = 1'b1;
      #1;
      checks++; if (bus.div_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", bus.div_req_ready); end
      bus.div_req_valid = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      #1;
      checks++; if (bus.div_req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", bus.div_req_ready); end
   endtask

   // Issue one op, check latency and both results, then consume it
   task automatic test_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
      int n;
      do_issue(op, a, b);
      wait_resp(n);
      checks++; if (n !== 33) begin errors++; $display("FAIL %s_latency got %0d exp 33", name, n); end
      checks++; if (bus.div_quotient !== eq) begin errors++; $display("FAIL %s_q got %h exp %h", name, bus.div_quotient, eq); end
      checks++; if (bus.div_remainder !== er) begin errors++; $display("FAIL %s_r got %h exp %h", name, bus.div_remainder, er); end
      take_resp();
      checks++; if (bus.div_resp_valid !== 1'b0) begin errors++; $display("FAIL %s_handoff got %b exp 0", name, bus.div_resp_valid); end
   endtask

   task automatic test_backpressure_back_to_back();
      int n;
      do_issue(4'b0010, 32'd100, 32'd9);
      wait_resp(n);
      checks++; if (n !== 33) begin errors++; $display("FAIL bp_latency got %0d exp 33", n); end
      // Queue the next request while the consumer stalls
      bus.div_req_valid = 1'b1;
      bus.div_op        = 4'b0010;
      bus.div_src1      = 32'd50;
      bus.div_src2      = 32'd7;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.div_resp_valid !== 1'b1 || bus.div_quotient !== 32'd11 ||
             bus.div_remainder !== 32'd1 || bus.div_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d got v=%b q=%h r=%h rdy=%b exp v=1 q=b r=1 rdy=0", i,
                     bus.div_resp_valid, bus.div_quotient, bus.div_remainder, bus.div_req_ready);
         end
      end
      bus.div_resp_ready = 1'b1;
      #1;
      checks++; if (bus.div_req_ready !== 1'b1) begin errors++; $display("FAIL bp_same_edge_ready got %b exp 1", bus.div_req_ready); end
      @(posedge clk); #1;
      bus.div_resp_ready = 1'b0;
      bus.div_req_valid  = 1'b0;
      bus.div_src1       = 32'hFFFF_0000;
      checks++; if (bus.div_resp_valid !== 1'b0 || bus.div_busy !== 1'b1) begin
         errors++; $display("FAIL bp_b2b_accept got v=%b busy=%b exp v=0 busy=1", bus.div_resp_valid, bus.div_busy);
      end
      wait_resp(n);
      checks++; if (n !== 33) begin errors++; $display("FAIL b2b_latency got %0d exp 33", n); end
      checks++; if (bus.div_quotient !== 32'd7) begin errors++; $display("FAIL b2b_q got %h exp 7", bus.div_quotient); end
      checks++; if (bus.div_remainder !== 32'd1) begin errors++; $display("FAIL b2b_r got %h exp 1", bus.div_remainder); end
      take_resp();
   endtask

   task automatic test_cancel();
      int seen;
      do_issue(4'b0010, 32'd1000, 32'd10);
      repeat (10) @(posedge clk);
      #1;
      bus.div_cancel = 1'b1;
      @(posedge clk); #1;
      bus.div_cancel = 1'b0;
      #1;
      checks++; if (bus.div_busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b exp 0", bus.div_busy); end
      checks++; if (bus.div_req_ready !== 1'b1) begin errors++; $display("FAIL cancel_ready got %b exp 1", bus.div_req_ready); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.div_resp_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL cancel_no_resp got %0d exp 0", seen); end
      test_op("post_cancel", 4'b0010, 32'd1000, 32'd10, 32'd100, 32'd0);
   endtask

   task automatic test_reset_in_done();
      int n;
      do_issue(4'b0001, 32'd20, 32'hFFFF_FFFD);
      wait_resp(n);
      checks++; if (bus.div_quotient !== 32'hFFFF_FFFA || bus.div_remainder !== 32'd2) begin
         errors++; $display("FAIL rd_result got q=%h r=%h exp q=fffffffa r=2", bus.div_quotient, bus.div_remainder);
      end
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      checks++; if (bus.div_resp_valid !== 1'b0) begin errors++; $display("FAIL rd_valid got %b exp 0", bus.div_resp_valid); end
      checks++; if (bus.div_quotient !== 32'h0 || bus.div_remainder !== 32'h0) begin
         errors++; $display("FAIL rd_clear got q=%h r=%h exp 0", bus.div_quotient, bus.div_remainder);
      end
      checks++; if (bus.div_busy !== 1'b0) begin errors++; $display("FAIL rd_idle got busy=%b exp 0", bus.div_busy); end
   endtask

   initial begin
      clk                = 1'b0;
      resetn             = 1'b0;
      checks             = 0;
      errors             = 0;
      bus.div_req_valid  = 1'b0;
      bus.div_op         = 4'b0000;
      bus.div_src1       = 32'h0;
      bus.div_src2       = 32'h0;
      bus.div_cancel     = 1'b0;
      bus.div_resp_ready = 1'b0;

      test_reset();
      test_op("divw_neg",   4'b0001, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
      test_op("divwu",      4'b0010, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 32'd1);
      test_op("overflow",   4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
      test_op("modwu_zero", 4'b1000, 32'd100,       32'd0,        32'hFFFF_FFFF, 32'h0000_0064);
      test_op("divw_zero",  4'b0001, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB);
      test_op("multihot",   4'b0101, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE);
      test_op("modw_pos",   4'b0100, 32'd17,        32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'd2);
      test_backpressure_back_to_back();
      test_cancel();
      test_reset_in_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
